// File: rtl/pca_pkg.sv
// Shared definitions for the systolic MAC processing element: default
// widths, the default dot-product length and the control state encoding.
package pca_pkg;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_ACC_W   = 24;
  localparam int DEF_N_TERMS = 4;

  // IDLE means no partial dot product is held (count and accumulator are zero).
  // ACCUM means at least one term, but not all terms, has been added.
  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } pe_state_e;

endpackage

// File: rtl/mac_sat_add.sv
// Saturating accumulator adder. Both operands are widened by one bit so the
// carry/sign of the true sum is visible. A sum outside the representable
// range is clamped to the nearest limit, and sat_o flags that clamp.
module mac_sat_add #(
  parameter int ACC_W  = 24,
  parameter int SIGNED = 0
) (
  input  logic [ACC_W-1:0] acc_i,
  input  logic [ACC_W-1:0] addend_i,
  output logic [ACC_W-1:0] sum_o,
  output logic             sat_o
);

  logic [ACC_W:0] accExt;
  logic [ACC_W:0] addExt;
  logic [ACC_W:0] rawSum;

  // Widen both operands, add them, then clamp the result into ACC_W bits.
  always_comb begin
    accExt = {(SIGNED != 0) && acc_i[ACC_W-1], acc_i};
    addExt = {(SIGNED != 0) && addend_i[ACC_W-1], addend_i};
    rawSum = accExt + addExt;
    sum_o  = rawSum[ACC_W-1:0];
    sat_o  = 1'b0;
    if (SIGNED != 0) begin
      if (rawSum[ACC_W] != rawSum[ACC_W-1]) begin
        sat_o = 1'b1;
        sum_o = rawSum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end
    end else if (rawSum[ACC_W]) begin
      sat_o = 1'b1;
      sum_o = '1;
    end
  end

endmodule

// File: rtl/systolic_mac_pe.sv
// Systolic multiply-accumulate PE. Operands are forwarded to the neighbouring
// PEs one cycle later. Stage 1 registers the product. Stage 2 adds the product
// into a saturating accumulator. After N_TERMS adds, the completed dot product
// moves into a result register that a consumer holds with a ready handshake.
module systolic_mac_pe
  import pca_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ACC_W   = DEF_ACC_W,
  parameter int N_TERMS = DEF_N_TERMS,
  parameter int SIGNED  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              acc_clr,
  output logic              pass_valid,
  output logic [DATA_W-1:0] pass_a,
  output logic [DATA_W-1:0] pass_b,
  output logic              res_valid,
  output logic [ACC_W-1:0]  res_data,
  output logic              res_sat,
  input  logic              res_ready,
  output logic              res_ovf,
  output logic              busy
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int CNT_W  = $clog2(N_TERMS + 1);

  logic              passValid_q;
  logic [DATA_W-1:0] passA_q;
  logic [DATA_W-1:0] passB_q;

  logic signed [PROD_W-1:0] aSigned;
  logic signed [PROD_W-1:0] bSigned;
  logic [PROD_W-1:0]        aUnsigned;
  logic [PROD_W-1:0]        bUnsigned;
  logic [PROD_W-1:0]        product_d;
  logic [PROD_W-1:0]        prod_q;
  logic                     prodValid_q;

  pe_state_e         state_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;
  logic [ACC_W-1:0]  acc_q;
  logic              sat_q;
  logic [ACC_W-1:0]  addend;
  logic [ACC_W-1:0]  sum;
  logic              addSat;
  logic              lastTerm;

  logic              resValid_q;
  logic [ACC_W-1:0]  resData_q;
  logic              resSat_q;
  logic              resOvf_q;

  // Extend the operands to product width first, so the multiply is exact in both modes.
  always_comb begin
    aSigned   = PROD_W'($signed(in_a));
    bSigned   = PROD_W'($signed(in_b));
    aUnsigned = PROD_W'(in_a);
    bUnsigned = PROD_W'(in_b);
    product_d = (SIGNED != 0) ? PROD_W'(aSigned * bSigned) : (aUnsigned * bUnsigned);
  end

  // Bring the stored product up to accumulator width with the correct extension.
  always_comb begin
    addend = (SIGNED != 0) ? ACC_W'($signed(prod_q)) : ACC_W'(prod_q);
  end

  assign count_d  = count_q + CNT_W'(1);
  assign lastTerm = (count_d == CNT_W'(N_TERMS));

  mac_sat_add #(
    .ACC_W (ACC_W),
    .SIGNED(SIGNED)
  ) uSatAdd (
    .acc_i   (acc_q),
    .addend_i(addend),
    .sum_o   (sum),
    .sat_o   (addSat)
  );

  // Forward the operands and capture the stage-1 product. These registers run every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      passValid_q <= 1'b0;
      passA_q     <= '0;
      passB_q     <= '0;
      prodValid_q <= 1'b0;
      prod_q      <= '0;
    end else begin
      passValid_q <= in_valid;
      passA_q     <= in_a;
      passB_q     <= in_b;
      prodValid_q <= in_valid;
      prod_q      <= product_d;
    end
  end

  // Accumulation FSM and result register. acc_clr drops the in-flight product,
  // but the operand pair arriving in the same cycle still enters stage 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      acc_q      <= '0;
      sat_q      <= 1'b0;
      resValid_q <= 1'b0;
      resData_q  <= '0;
      resSat_q   <= 1'b0;
      resOvf_q   <= 1'b0;
    end else begin
      if (resValid_q && res_ready) begin
        resValid_q <= 1'b0;
      end
      if (acc_clr) begin
        state_q <= IDLE;
        count_q <= '0;
        acc_q   <= '0;
        sat_q   <= 1'b0;
      end else if (prodValid_q) begin
        if (lastTerm) begin
          resValid_q <= 1'b1;
          resData_q  <= sum;
          resSat_q   <= sat_q | addSat;
          if (resValid_q && !res_ready) begin
            resOvf_q <= 1'b1;
          end
          state_q <= IDLE;
          count_q <= '0;
          acc_q   <= '0;
          sat_q   <= 1'b0;
        end else begin
          state_q <= ACCUM;
          count_q <= count_d;
          acc_q   <= sum;
          sat_q   <= sat_q | addSat;
        end
      end
    end
  end

  assign pass_valid = passValid_q;
  assign pass_a     = passA_q;
  assign pass_b     = passB_q;
  assign res_valid  = resValid_q;
  assign res_data   = resData_q;
  assign res_sat    = resSat_q;
  assign res_ovf    = resOvf_q;
  assign busy       = (state_q == ACCUM);

endmodule

// File: tb/tb_systolic_mac_pe.sv
// Testbench for systolic_mac_pe. Three instances share one input stream:
//   0: unsigned, ACC_W=24, N_TERMS=4
//   1: signed,   ACC_W=16, N_TERMS=4
//   2: signed,   ACC_W=24, N_TERMS=2
// A term-level model predicts every output of each instance on every cycle.
module tb_systolic_mac_pe;

  localparam int NCFG = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       inValid;
  logic [7:0] inA;
  logic [7:0] inB;
  logic       accClr;
  logic       resReady;

  logic [NCFG-1:0] oPassV;
  logic [7:0]      oPassA [NCFG];
  logic [7:0]      oPassB [NCFG];
  logic [NCFG-1:0] oResV;
  logic [NCFG-1:0] oResSat;
  logic [NCFG-1:0] oOvf;
  logic [NCFG-1:0] oBusy;
  logic [23:0]     oData0;
  logic [15:0]     oData1;
  logic [23:0]     oData2;

  int vectors     = 0;
  int miscompares = 0;

  // Model state for each configuration.
  longint mAcc      [NCFG];
  int     mCnt      [NCFG];
  bit     mSat      [NCFG];
  bit     pendValid [NCFG];
  longint pendData  [NCFG];
  bit     pendSat   [NCFG];
  bit     mResValid [NCFG];
  longint mResData  [NCFG];
  bit     mResSat   [NCFG];
  bit     mOvf      [NCFG];
  bit     mBusy     [NCFG];
  bit         mPassV;
  logic [7:0] mPassA;
  logic [7:0] mPassB;

  always #5 clk = ~clk;

  systolic_mac_pe #(.DATA_W(8), .ACC_W(24), .N_TERMS(4), .SIGNED(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_a(inA), .in_b(inB), .acc_clr(accClr),
    .pass_valid(oPassV[0]), .pass_a(oPassA[0]), .pass_b(oPassB[0]),
    .res_valid(oResV[0]), .res_data(oData0), .res_sat(oResSat[0]),
    .res_ready(resReady), .res_ovf(oOvf[0]), .busy(oBusy[0]));

  systolic_mac_pe #(.DATA_W(8), .ACC_W(16), .N_TERMS(4), .SIGNED(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_a(inA), .in_b(inB), .acc_clr(accClr),
    .pass_valid(oPassV[1]), .pass_a(oPassA[1]), .pass_b(oPassB[1]),
    .res_valid(oResV[1]), .res_data(oData1), .res_sat(oResSat[1]),
    .res_ready(resReady), .res_ovf(oOvf[1]), .busy(oBusy[1]));

  systolic_mac_pe #(.DATA_W(8), .ACC_W(24), .N_TERMS(2), .SIGNED(1)) dut2 (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_a(inA), .in_b(inB), .acc_clr(accClr),
    .pass_valid(oPassV[2]), .pass_a(oPassA[2]), .pass_b(oPassB[2]),
    .res_valid(oResV[2]), .res_data(oData2), .res_sat(oResSat[2]),
    .res_ready(resReady), .res_ovf(oOvf[2]), .busy(oBusy[2]));

  function automatic bit cfgSigned(input int c);
    return (c != 0);
  endfunction

  function automatic int cfgAccW(input int c);
    return (c == 1) ? 16 : 24;
  endfunction

  function automatic int cfgN(input int c);
    return (c == 2) ? 2 : 4;
  endfunction

  function automatic longint maxVal(input int c);
    if (cfgSigned(c)) return (longint'(1) << (cfgAccW(c) - 1)) - 1;
    return (longint'(1) << cfgAccW(c)) - 1;
  endfunction

  function automatic longint minVal(input int c);
    if (cfgSigned(c)) return -(longint'(1) << (cfgAccW(c) - 1));
    return 0;
  endfunction

  function automatic longint operand(input logic [7:0] v, input int c);
    if (cfgSigned(c) && v[7]) return longint'(v) - 256;
    return longint'(v);
  endfunction

  function automatic logic [31:0] observedData(input int c);
    if (c == 0) return 32'(oData0);
    if (c == 1) return 32'(oData1);
    return 32'(oData2);
  endfunction

  task automatic check(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s[%0d] observed=%0h expected=%0h", tag, c, obs, exp);
    end
  endtask

  // Advance the model by one rising edge, using the inputs held across that edge.
  task automatic modelEdge();
    mPassV = rst ? 1'b0 : inValid;
    mPassA = rst ? 8'h00 : inA;
    mPassB = rst ? 8'h00 : inB;
    for (int c = 0; c < NCFG; c++) begin
      int     cntPrev;
      longint s;
      cntPrev = mCnt[c];
      if (rst) begin
        mAcc[c] = 0; mCnt[c] = 0; mSat[c] = 0; pendValid[c] = 0;
        mResValid[c] = 0; mResData[c] = 0; mResSat[c] = 0; mOvf[c] = 0; mBusy[c] = 0;
      end else begin
        if (pendValid[c] && !accClr) begin
          if (mResValid[c] && !resReady) mOvf[c] = 1;
          mResValid[c] = 1;
          mResData[c]  = pendData[c];
          mResSat[c]   = pendSat[c];
        end else if (mResValid[c] && resReady) begin
          mResValid[c] = 0;
        end
        pendValid[c] = 0;
        mBusy[c] = !accClr && (cntPrev != 0);
        if (accClr) begin
          mAcc[c] = 0; mSat[c] = 0; mCnt[c] = 0;
        end
        if (inValid) begin
          s = mAcc[c] + operand(inA, c) * operand(inB, c);
          if (s > maxVal(c)) begin s = maxVal(c); mSat[c] = 1; end
          else if (s < minVal(c)) begin s = minVal(c); mSat[c] = 1; end
          mAcc[c] = s;
          mCnt[c]++;
          if (mCnt[c] == cfgN(c)) begin
            pendValid[c] = 1; pendData[c] = mAcc[c]; pendSat[c] = mSat[c];
            mAcc[c] = 0; mSat[c] = 0; mCnt[c] = 0;
          end
        end
      end
    end
  endtask

  // Compare every output of every instance against the model.
  task automatic checkOutput();
    for (int c = 0; c < NCFG; c++) begin
      longint mask;
      mask = (longint'(1) << cfgAccW(c)) - 1;
      check("pass_valid", c, 32'(oPassV[c]), 32'(mPassV));
      check("pass_a", c, 32'(oPassA[c]), 32'(mPassA));
      check("pass_b", c, 32'(oPassB[c]), 32'(mPassB));
      check("res_valid", c, 32'(oResV[c]), 32'(mResValid[c]));
      check("res_data", c, observedData(c), 32'(mResData[c] & mask));
      check("res_sat", c, 32'(oResSat[c]), 32'(mResSat[c]));
      check("res_ovf", c, 32'(oOvf[c]), 32'(mOvf[c]));
      check("busy", c, 32'(oBusy[c]), 32'(mBusy[c]));
    end
  endtask

  // Drive one cycle of inputs, step the model at the edge, then check #1 later.
  task automatic applyStimulus(input bit r, input bit v, input logic [7:0] a, input logic [7:0] b,
                               input bit clr, input bit rdy);
    rst = r; inValid = v; inA = a; inB = b; accClr = clr; resReady = rdy;
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput();
  endtask

  initial begin
    rst = 1'b1; inValid = 1'b0; inA = 8'h00; inB = 8'h00; accClr = 1'b0; resReady = 1'b0;

    // Reset state.
    applyStimulus(1, 0, 8'h00, 8'h00, 0, 0);
    applyStimulus(1, 1, 8'h11, 8'h22, 0, 0);
    check("reset_res_valid", 0, 32'(oResV[0]), 32'd0);
    check("reset_pass_a", 0, 32'(oPassA[0]), 32'd0);

    // Unsigned dot product 1*2+3*4+5*6+7*8 = 100.
    applyStimulus(0, 1, 8'd1, 8'd2, 0, 0);
    applyStimulus(0, 1, 8'd3, 8'd4, 0, 0);
    applyStimulus(0, 1, 8'd5, 8'd6, 0, 0);
    applyStimulus(0, 1, 8'd7, 8'd8, 0, 0);
    check("sum100_not_yet", 0, 32'(oResV[0]), 32'd0);
    applyStimulus(0, 0, 8'd0, 8'd0, 0, 0);
    check("sum100_valid", 0, 32'(oResV[0]), 32'd1);
    check("sum100_data", 0, 32'(oData0), 32'd100);
    check("sum100_sat", 0, 32'(oResSat[0]), 32'd0);
    applyStimulus(0, 0, 8'd0, 8'd0, 1, 1);
    check("consume_valid", 0, 32'(oResV[0]), 32'd0);

    // Signed saturation at ACC_W=16: (-128)*(-128) four times.
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 8'h80, 8'h80, 0, 0);
    applyStimulus(0, 0, 8'd0, 8'd0, 0, 0);
    check("sat_data", 1, 32'(oData1), 32'h7FFF);
    check("sat_flag", 1, 32'(oResSat[1]), 32'd1);
    check("nosat_data", 0, 32'(oData0), 32'h10000);
    applyStimulus(0, 0, 8'd0, 8'd0, 1, 1);

    // Signed two-term product: (-3)*5 + 2*2 = -11.
    applyStimulus(0, 1, 8'hFD, 8'd5, 0, 0);
    applyStimulus(0, 1, 8'd2, 8'd2, 0, 0);
    applyStimulus(0, 0, 8'd0, 8'd0, 0, 0);
    check("neg11_data", 2, 32'(oData2), 32'h00FFFFF5);
    applyStimulus(0, 0, 8'd0, 8'd0, 1, 1);

    // Back-to-back results with ready high: the overflow flag stays clear.
    for (int i = 0; i < 8; i++) applyStimulus(0, 1, 8'($urandom), 8'($urandom), 0, 1);
    applyStimulus(0, 0, 8'd0, 8'd0, 0, 1);
    check("ovf_ready_clear", 0, 32'(oOvf[0]), 32'd0);
    applyStimulus(0, 0, 8'd0, 8'd0, 0, 1);

    // Back-to-back results with ready low: the second result overwrites the first.
    for (int i = 0; i < 8; i++) applyStimulus(0, 1, 8'd1, 8'd1, 0, 0);
    check("ovf_before_second", 0, 32'(oOvf[0]), 32'd0);
    applyStimulus(0, 0, 8'd0, 8'd0, 0, 0);
    check("ovf_set", 0, 32'(oOvf[0]), 32'd1);
    check("ovf_data", 0, 32'(oData0), 32'd4);

    // Abort after two terms; the pair arriving with acc_clr starts the new product.
    applyStimulus(0, 0, 8'd0, 8'd0, 1, 1);
    applyStimulus(0, 1, 8'd4, 8'd4, 0, 1);
    applyStimulus(0, 1, 8'd5, 8'd5, 0, 1);
    applyStimulus(0, 1, 8'd2, 8'd3, 1, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 8'd1, 8'd1, 0, 1);
    applyStimulus(0, 0, 8'd0, 8'd0, 0, 0);
    check("clr_valid", 0, 32'(oResV[0]), 32'd1);
    check("clr_data", 0, 32'(oData0), 32'd9);

    // Reset in the middle of a dot product.
    applyStimulus(0, 1, 8'd9, 8'd9, 0, 0);
    applyStimulus(0, 1, 8'd8, 8'd8, 0, 0);
    applyStimulus(1, 1, 8'h55, 8'hAA, 0, 0);
    check("rst_busy", 0, 32'(oBusy[0]), 32'd0);
    check("rst_ovf", 0, 32'(oOvf[0]), 32'd0);
    check("rst_pass_b", 0, 32'(oPassB[0]), 32'd0);
    applyStimulus(0, 1, 8'h12, 8'h34, 0, 0);
    check("post_rst_pass_a", 0, 32'(oPassA[0]), 32'h12);

    // Randomised traffic checked cycle by cycle against the model.
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7),
                    8'($urandom), 8'($urandom),
                    ($urandom_range(0, 29) == 0), ($urandom_range(0, 1) == 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
